// File: rtl/press_classifier.sv
// press_classifier: classifies debounced button presses as short, long or double.
// Optional feature macro: PRESS_REPEAT_EN (long_tick auto-repeat while held after a long press).
// Ports: clk, reset_n (async active-low), level (debounced, 1 = pressed),
//        short_tick / long_tick / double_tick (one-cycle pulses), press_count (saturating), busy.
// Latency: all outputs registered; timer-driven ticks arrive N*TICK_DIV+1 cycles after state entry.
module press_classifier #(
  parameter int TICK_DIV = 100_000,
  parameter int LONG_MS  = 800,
  parameter int GAP_MS   = 250,
  parameter int MS_W     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level,
  output logic       short_tick,
  output logic       long_tick,
  output logic       double_tick,
  output logic [7:0] press_count,
  output logic       busy
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0] LONG_CNT = MS_W'(LONG_MS);
  localparam logic [MS_W-1:0] GAP_CNT  = MS_W'(GAP_MS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESS1 = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_PRESS2 = 3'd3;
  localparam logic [2:0] S_HELD   = 3'd4;

  logic [2:0]      state, state_nxt;
  logic [PS_W-1:0] prescaler;
  logic [MS_W-1:0] ms_cnt;
  logic            short_nxt, long_nxt, double_nxt;
  logic            restart;   // clears the timebase without a state change

`ifdef PRESS_REPEAT_EN
  // Set only when HELD was reached from a single long press; a long-held
  // double press or a button held through reset never auto-repeats.
  logic repeat_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repeat_ok <= 1'b0;
    end else begin
      repeat_ok <= (state_nxt == S_HELD) &&
                   ((state == S_PRESS1) || repeat_ok);
    end
  end
`endif

  // Level changes are tested before timer expiry so they win on a tie.
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    restart    = 1'b0;
    case (state)
      S_IDLE: begin
        if (level) state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (!level) begin
          state_nxt = S_GAP;
        end else if (ms_cnt == LONG_CNT) begin
          state_nxt = S_HELD;
          long_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        if (level) begin
          state_nxt = S_PRESS2;
        end else if (ms_cnt == GAP_CNT) begin
          state_nxt = S_IDLE;
          short_nxt = 1'b1;
        end
      end
      S_PRESS2: begin
        if (!level) begin
          state_nxt  = S_IDLE;
          double_nxt = 1'b1;
        end else if (ms_cnt == LONG_CNT) begin
          state_nxt  = S_HELD;
          double_nxt = 1'b1;
        end
      end
      S_HELD: begin
        if (!level) begin
          state_nxt = S_IDLE;
        end
`ifdef PRESS_REPEAT_EN
        else if (repeat_ok && (ms_cnt == GAP_CNT)) begin
          long_nxt = 1'b1;
          restart  = 1'b1;
        end
`else
        // Without auto-repeat HELD only waits for the release.
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_HELD;
      prescaler   <= '0;
      ms_cnt      <= '0;
      short_tick  <= 1'b0;
      long_tick   <= 1'b0;
      double_tick <= 1'b0;
      press_count <= 8'd0;
      busy        <= 1'b1;
    end else begin
      state       <= state_nxt;
      short_tick  <= short_nxt;
      long_tick   <= long_nxt;
      double_tick <= double_nxt;
      busy        <= (state_nxt != S_IDLE);

      // Every state change (or repeat) restarts the millisecond timebase.
      if ((state_nxt != state) || restart) begin
        prescaler <= '0;
        ms_cnt    <= '0;
      end else if (prescaler == PS_LAST) begin
        prescaler <= '0;
        if (ms_cnt != {MS_W{1'b1}}) ms_cnt <= ms_cnt + MS_W'(1);
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end

      if ((short_nxt || long_nxt || double_nxt) && (press_count != 8'hFF))
        press_count <= press_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: randomized gesture stimulus with a timing-level reference model
// feeding an expected-event queue; a negedge monitor pops and compares every tick.
module tb_press_classifier;

  localparam int T = 4;
  localparam int L = 10;
  localparam int G = 3;
  localparam int LONG_C = L * T + 1;   // cycles from press entry to long/hold expiry
  localparam int GAP_C  = G * T + 1;   // cycles from release to short expiry

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       level = 1'b0;
  logic       short_tick, long_tick, double_tick, busy;
  logic [7:0] press_count;

  press_classifier #(.TICK_DIV(T), .LONG_MS(L), .GAP_MS(G), .MS_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .level(level),
    .short_tick(short_tick), .long_tick(long_tick), .double_tick(double_tick),
    .press_count(press_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;   // posedge count; at a negedge it equals the index of the last edge
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int kind; int cnt; } ev_t;   // kind: 0 short, 1 long, 2 double
  ev_t exp_q[$];
  int  cnt_model = 0;
  int  checks = 0;
  int  errors = 0;

  function automatic void chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(input int c, input int k);
    ev_t e;
    cnt_model = (cnt_model < 255) ? cnt_model + 1 : 255;
    e.cyc = c; e.kind = k; e.cnt = cnt_model;
    exp_q.push_back(e);
  endfunction

  // Monitor: every tick must match the head of the queue in kind, cycle and count.
  always @(negedge clk) begin
    int  nt;
    int  kind;
    ev_t e;
    nt = int'(short_tick) + int'(long_tick) + int'(double_tick);
    if (nt > 1) chk(1'b0, "one_tick_per_cycle", nt, 1);
    if (nt == 1) begin
      kind = short_tick ? 0 : (long_tick ? 1 : 2);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_tick_kind", kind, -1);
      end else begin
        e = exp_q.pop_front();
        chk(kind == e.kind, "tick_kind", kind, e.kind);
        chk(cyc == e.cyc, "tick_cycle", cyc, e.cyc);
        chk(int'(press_count) == e.cnt, "tick_count", int'(press_count), e.cnt);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk(1'b0, "missed_tick_at", cyc, e.cyc);
    end
  end

  // Single press of p cycles starting from IDLE, then tail cycles low.
  // Short if the release edge is no later than the long expiry edge.
  task automatic do_single(input int p, input int tail);
    int k, e, r;
    k = cyc; e = k + 1; r = k + p + 1;
    if (p <= LONG_C) begin
      push(r + GAP_C, 0);
    end else begin
      push(e + LONG_C, 1);
`ifdef PRESS_REPEAT_EN
      for (int j = 1; e + LONG_C + GAP_C * j < r; j++) push(e + LONG_C + GAP_C * j, 1);
`endif
    end
    level = 1'b1;
    repeat (p) @(negedge clk);
    chk(busy == 1'b1, "busy_pressed", int'(busy), 1);
    level = 1'b0;
    repeat (tail) @(negedge clk);
    chk(busy == 1'b0, "busy_after_single", int'(busy), 0);
  endtask

  // Double press: p1 (<= LONG_C), gap g (1..GAP_C), second press p2, tail low.
  task automatic do_double(input int p1, input int g, input int p2, input int tail);
    int k2;
    k2 = cyc + p1 + g;
    if (p2 <= LONG_C) push(k2 + p2 + 1, 2);
    else              push(k2 + 1 + LONG_C, 2);
    level = 1'b1;
    repeat (p1) @(negedge clk);
    level = 1'b0;
    repeat (g) @(negedge clk);
    level = 1'b1;
    repeat (p2) @(negedge clk);
    chk(busy == 1'b1, "busy_press2", int'(busy), 1);
    level = 1'b0;
    repeat (tail) @(negedge clk);
    chk(busy == 1'b0, "busy_after_double", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(short_tick == 1'b0,  {tag, "_short"},  int'(short_tick), 0);
    chk(long_tick == 1'b0,   {tag, "_long"},   int'(long_tick), 0);
    chk(double_tick == 1'b0, {tag, "_double"}, int'(double_tick), 0);
    chk(press_count == 8'd0, {tag, "_count"},  int'(press_count), 0);
    chk(busy == 1'b1,        {tag, "_busy"},   int'(busy), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "busy_idle_after_reset", int'(busy), 0);

    // Directed gestures and boundaries
    do_single(60, 5);          // long (plus one repeat when enabled)
    do_single(5, 20);          // short
    do_double(5, 6, 5, 5);     // double
    do_single(LONG_C, 14);     // release on expiry edge -> short
    do_single(LONG_C + 1, 3);  // one cycle more -> long
    do_double(5, GAP_C, 5, 3); // longest gap still double
    do_single(5, GAP_C + 1);   // shortest gap that is two shorts
    do_single(5, 20);
    do_double(3, 2, 50, 3);    // long-held double

    // Button held through reset: never classified
    level = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_held");
    exp_q.delete();
    cnt_model = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk(busy == 1'b1, "busy_held_through_reset", int'(busy), 1);
    chk(press_count == 8'd0, "count_held_through_reset", int'(press_count), 0);
    level = 1'b0;
    repeat (3) @(negedge clk);
    do_single(5, 20);

    // Random gestures
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       do_single(int'($urandom_range(1, LONG_C)), int'($urandom_range(GAP_C + 1, 20)));
        1:       do_single(int'($urandom_range(LONG_C + 1, 80)), int'($urandom_range(1, 4)));
        default: do_double(int'($urandom_range(1, LONG_C)), int'($urandom_range(1, GAP_C)),
                           int'($urandom_range(1, 60)), int'($urandom_range(1, 4)));
      endcase
    end

    // Saturation
    for (int i = 0; i < 300; i++) do_single(int'($urandom_range(1, 10)), GAP_C + 1);
    chk(press_count == 8'd255, "count_saturated", int'(press_count), 255);

    // Reset mid-PRESS1 clears everything at once
    level = 1'b1;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_press");
    exp_q.delete();
    cnt_model = 0;
    repeat (2) @(negedge clk);
    level = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    do_single(5, 20);
    chk(press_count == 8'd1, "count_after_mid_reset", int'(press_count), 1);

    repeat (30) @(negedge clk);
    chk(exp_q.size() == 0, "pending_expected_events", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Downstream consumer of the debouncer output. Takes one clean, debounced button level and classifies each press gesture as short, long or double.
- Emits a one-cycle pulse for each classified gesture and keeps a saturating count of gestures.
- Sits between the debouncer and the user-logic/display stage, replacing raw edge detection where gesture semantics are needed.

Parameters:
- TICK_DIV, 100_000, clk cycles per millisecond tick (100 MHz clk -> 1 ms); minimum 2.
- LONG_MS, 800, hold time in ms that qualifies a long press; >= 1.
- GAP_MS, 250, maximum release gap in ms between the two presses of a double press; >= 1.
- MS_W, 16, width of the millisecond counter; must hold max(LONG_MS, GAP_MS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- level  input  1  debounced button level, synchronous to clk, 1 = pressed.
- short_tick  output  1  one-cycle pulse: single short press completed.
- long_tick  output  1  one-cycle pulse: long-press threshold reached.
- double_tick  output  1  one-cycle pulse: second press of a double press.
- press_count  output  8  number of classified gestures, saturating at 255.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, PRESS1, GAP, PRESS2, HELD. All outputs are registered.
- Reset (reset_n low, asynchronous): state = HELD, prescaler = 0, ms_cnt = 0, all ticks = 0, press_count = 0, busy = 1. A button held through reset is therefore never classified; the block waits for the release.
- Timebase:
  - 0..TICK_DIV-1 prescaler increments every cycle; ms_cnt increments (saturating at all-ones) when the prescaler wraps.
  - Prescaler and ms_cnt both clear to 0 on every state change.
- Transitions (level sampled at each edge):
  - IDLE: level=1 -> PRESS1.
  - PRESS1: level=0 -> GAP. Otherwise, if ms_cnt == LONG_MS -> HELD and assert long_tick.
  - GAP: level=1 -> PRESS2. Otherwise, if ms_cnt == GAP_MS -> IDLE and assert short_tick.
  - PRESS2: level=0 -> IDLE and assert double_tick. Otherwise, if ms_cnt == LONG_MS -> HELD and assert double_tick (a double press held long still counts as double).
  - HELD: level=0 -> IDLE; no pulse.
  - Any illegal state encoding -> IDLE.
- Simultaneous events: a level change takes priority over timer expiry in the same cycle, so PRESS1 seeing level=0 with ms_cnt == LONG_MS goes to GAP with no long_tick.
- Latency:
  - Entry to PRESS1 at edge E gives long_tick high in the cycle starting at edge E + LONG_MS*TICK_DIV + 1.
  - Entry to GAP at edge R gives short_tick at edge R + GAP_MS*TICK_DIV + 1.
  - double_tick is asserted on the edge that samples the release.
- Pulses: each tick is high for exactly one cycle. At most one tick is asserted in any cycle.
- press_count: increments by 1 in the same cycle any tick is asserted; holds at 255 and does not wrap.
- Reset mid-gesture: all outputs clear immediately and no pending tick is emitted.

Optional Feature:
- PRESS_REPEAT_EN defined:
  - In HELD while level=1, long_tick re-pulses every GAP_MS ms; the first repeat comes GAP_MS*TICK_DIV+1 cycles after HELD entry.
  - Each repeat increments press_count.
  - HELD entered from PRESS2 never repeats.
- Macro undefined: HELD emits no pulses, and the repeat logic is absent from the netlist.

Test Plan:
- TICK_DIV=4, LONG_MS=10, GAP_MS=3. Deassert reset_n with level=0; raise level at edge 0 and hold -> long_tick single pulse in the cycle after edge 41, busy=1 until release, press_count=1.
- Same parameters: level high 5 cycles then low, stays low -> short_tick single pulse 13 cycles after the release-sampling edge, press_count=1, busy=0 afterwards.
- level high 5, low 6, high 5, low -> double_tick on the edge sampling the second release, no short_tick, press_count=1.
- level held high across reset release -> no tick ever; after a release and a 5-cycle press, exactly one short_tick.
- 300 short presses -> press_count stops at 255. Assert reset_n low mid-PRESS1 -> all ticks 0, press_count 0 immediately.
- PRESS_REPEAT_EN defined, level held 60 cycles -> long_tick at cycle 41, repeats at 54 and 67 only if still held; press_count matches the number of pulses.
